// File: rtl/mod_line_xfer_sched_if.sv
// rtl/mod_line_xfer_sched_if.sv - cache-side and system-bus handshake bundle for the line transfer scheduler
interface mod_line_xfer_sched_if #(
   parameter int DATA_WIDTH = 512,
   parameter int BUS_WIDTH  = 64,
   parameter int TAG_WIDTH  = 13
);
   logic                  i_reqcyc;
   logic                  i_reqack;
   logic [BUS_WIDTH-1:0]  i_req;
   logic [TAG_WIDTH-1:0]  i_reqtag;
   logic                  i_respcyc;
   logic                  i_respack;
   logic [DATA_WIDTH-1:0] i_resp;
   logic [TAG_WIDTH-1:0]  i_resptag;

   logic                  d_reqcyc;
   logic                  d_reqack;
   logic [BUS_WIDTH-1:0]  d_req;
   logic [TAG_WIDTH-1:0]  d_reqtag;
   logic [DATA_WIDTH-1:0] d_reqdata;
   logic                  d_respcyc;
   logic                  d_respack;
   logic [DATA_WIDTH-1:0] d_resp;
   logic [TAG_WIDTH-1:0]  d_resptag;

   logic                  bus_reqcyc;
   logic                  bus_reqack;
   logic [BUS_WIDTH-1:0]  bus_req;
   logic [TAG_WIDTH-1:0]  bus_reqtag;
   logic                  bus_respcyc;
   logic                  bus_respack;
   logic [BUS_WIDTH-1:0]  bus_resp;
   logic [TAG_WIDTH-1:0]  bus_resptag;

   modport master (
      input  i_reqcyc, i_req, i_reqtag, i_respack,
      input  d_reqcyc, d_req, d_reqtag, d_reqdata, d_respack,
      input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
      output i_reqack, i_respcyc, i_resp, i_resptag,
      output d_reqack, d_respcyc, d_resp, d_resptag,
      output bus_reqcyc, bus_req, bus_reqtag, bus_respack
   );

   modport slave (
      output i_reqcyc, i_req, i_reqtag, i_respack,
      output d_reqcyc, d_req, d_reqtag, d_reqdata, d_respack,
      output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
      input  i_reqack, i_respcyc, i_resp, i_resptag,
      input  d_reqack, d_respcyc, d_resp, d_resptag,
      input  bus_reqcyc, bus_req, bus_reqtag, bus_respack
   );
endinterface

// File: rtl/mod_line_xfer_sched.sv
// rtl/mod_line_xfer_sched.sv - round-robin scheduler moving 64-byte lines between the L1 caches and the system bus
module mod_line_xfer_sched #(
   parameter int DATA_WIDTH = 512,
   parameter int BUS_WIDTH  = 64,
   parameter int TAG_WIDTH  = 13
) (
   input  logic                  clk,
   input  logic                  reset,
   mod_line_xfer_sched_if.master xif,
   output logic                  err_unexpected
);
   localparam int BEATS = DATA_WIDTH / BUS_WIDTH;
   localparam int CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [2:0] {IDLE, CMD, RD_BEATS, WR_BEATS, DELIVER} state_t;

   state_t                state;
   logic                  last_grant_d;
   logic                  owner_d;
   logic                  is_read;
   logic [TAG_WIDTH-1:0]  tag_q;
   logic [DATA_WIDTH-1:0] line_q;
   logic [CNT_W-1:0]      beat_cnt;
   logic                  i_reqack_q, d_reqack_q;
   logic                  bus_reqcyc_q;
   logic [BUS_WIDTH-1:0]  bus_req_q;
   logic [TAG_WIDTH-1:0]  bus_reqtag_q;
   logic                  i_respcyc_q, d_respcyc_q;
   logic [DATA_WIDTH-1:0] resp_q;
   logic [TAG_WIDTH-1:0]  resptag_q;
   logic                  err_q;

   logic                  pick_d;
   logic                  resp_taken;
   logic [CNT_W-1:0]      next_cnt;

   // DCache wins a tie unless it was the last one granted
   always_comb begin
      pick_d = 1'b0;
      if (xif.d_reqcyc && (!xif.i_reqcyc || !last_grant_d))
         pick_d = 1'b1;
   end

   assign resp_taken = owner_d ? xif.d_respack : xif.i_respack;
   assign next_cnt   = beat_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         last_grant_d <= 1'b0;
         owner_d      <= 1'b0;
         is_read      <= 1'b0;
         tag_q        <= '0;
         line_q       <= '0;
         beat_cnt     <= '0;
         i_reqack_q   <= 1'b0;
         d_reqack_q   <= 1'b0;
         bus_reqcyc_q <= 1'b0;
         bus_req_q    <= '0;
         bus_reqtag_q <= '0;
         i_respcyc_q  <= 1'b0;
         d_respcyc_q  <= 1'b0;
         resp_q       <= '0;
         resptag_q    <= '0;
         err_q        <= 1'b0;
      end else begin
         i_reqack_q <= 1'b0;
         d_reqack_q <= 1'b0;
         if (xif.bus_respcyc && state != RD_BEATS)
            err_q <= 1'b1;
         case (state)
            IDLE: begin
               if (xif.i_reqcyc || xif.d_reqcyc) begin
                  owner_d      <= pick_d;
                  last_grant_d <= pick_d;
                  i_reqack_q   <= !pick_d;
                  d_reqack_q   <= pick_d;
                  bus_reqcyc_q <= 1'b1;
                  bus_req_q    <= pick_d ? xif.d_req : xif.i_req;
                  bus_reqtag_q <= pick_d ? xif.d_reqtag : xif.i_reqtag;
                  tag_q        <= pick_d ? xif.d_reqtag : xif.i_reqtag;
                  // ICache can only read, whatever its tag bit 0 says
                  is_read      <= pick_d ? xif.d_reqtag[0] : 1'b1;
                  line_q       <= pick_d ? xif.d_reqdata : '0;
                  beat_cnt     <= '0;
                  state        <= CMD;
               end
            end
            CMD: begin
               if (xif.bus_reqack) begin
                  if (is_read) begin
                     bus_reqcyc_q <= 1'b0;
                     bus_req_q    <= '0;
                     bus_reqtag_q <= '0;
                     state        <= RD_BEATS;
                  end else begin
                     bus_req_q <= line_q[BUS_WIDTH-1:0];
                     state     <= WR_BEATS;
                  end
               end
            end
            WR_BEATS: begin
               if (xif.bus_reqack) begin
                  if (beat_cnt == LAST_BEAT) begin
                     bus_reqcyc_q <= 1'b0;
                     bus_req_q    <= '0;
                     bus_reqtag_q <= '0;
                     beat_cnt     <= '0;
                     resp_q       <= '0;
                     resptag_q    <= tag_q;
                     i_respcyc_q  <= !owner_d;
                     d_respcyc_q  <= owner_d;
                     state        <= DELIVER;
                  end else begin
                     beat_cnt  <= next_cnt;
                     bus_req_q <= line_q[BUS_WIDTH*next_cnt +: BUS_WIDTH];
                  end
               end
            end
            RD_BEATS: begin
               if (xif.bus_respcyc) begin
                  line_q[BUS_WIDTH*beat_cnt +: BUS_WIDTH] <= xif.bus_resp;
                  beat_cnt <= next_cnt;
                  if (beat_cnt == LAST_BEAT) begin
                     resp_q      <= {xif.bus_resp, line_q[DATA_WIDTH-BUS_WIDTH-1:0]};
                     resptag_q   <= xif.bus_resptag;
                     i_respcyc_q <= !owner_d;
                     d_respcyc_q <= owner_d;
                     state       <= DELIVER;
                  end
               end
            end
            DELIVER: begin
               if (resp_taken) begin
                  i_respcyc_q <= 1'b0;
                  d_respcyc_q <= 1'b0;
                  resp_q      <= '0;
                  resptag_q   <= '0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign xif.i_reqack    = i_reqack_q;
   assign xif.d_reqack    = d_reqack_q;
   assign xif.i_respcyc   = i_respcyc_q;
   assign xif.d_respcyc   = d_respcyc_q;
   assign xif.i_resp      = i_respcyc_q ? resp_q : '0;
   assign xif.d_resp      = d_respcyc_q ? resp_q : '0;
   assign xif.i_resptag   = i_respcyc_q ? resptag_q : '0;
   assign xif.d_resptag   = d_respcyc_q ? resptag_q : '0;
   assign xif.bus_reqcyc  = bus_reqcyc_q;
   assign xif.bus_req     = bus_req_q;
   assign xif.bus_reqtag  = bus_reqtag_q;
   assign xif.bus_respack = xif.bus_respcyc;
   assign err_unexpected  = err_q;
endmodule
